// File: rtl/acc_pkg.sv
// Shared accelerator types plus default sizing for the acc_mem_resp scratchpad responder.
package acc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam int ACC_MEM_DEPTH      = 256;
  localparam int ACC_MEM_READ_LAT   = 2;
  localparam int ACC_MEM_WBUF_DEPTH = 4;

endpackage

// File: rtl/acc_mem_wbuf.sv
// Write buffer for acc_mem_resp: FIFO of {idx, data} with a combinational
// youngest-match lookup so reads can forward data that has not yet drained.
module acc_mem_wbuf
  import acc_pkg::*;
#(
  parameter int DEPTH = ACC_MEM_WBUF_DEPTH,
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  data_t            push_data,
  input  logic             pop,
  output logic [IDX_W-1:0] pop_idx,
  output data_t            pop_data,
  output logic             empty,
  output logic             full_nxt,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_hit,
  output data_t            lkp_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] idx_q  [DEPTH];
  data_t            data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, slot;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: entry storage has no reset; count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_q[wr_ptr_q]  <= push_idx;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign pop_idx  = idx_q[rd_ptr_q];
  assign pop_data = data_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full_nxt = (count_d == CNT_W'(DEPTH));

  // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_data = '0;
    slot     = '0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (idx_q[slot] == lkp_idx)) begin
        lkp_hit  = 1'b1;
        lkp_data = data_q[slot];
      end
    end
  end

endmodule

// File: rtl/acc_mem_resp.sv
// Memory responder for acc_ctl: fixed-latency reads, buffered writes draining into a
// single-port array. Optional ACC_MEM_OOB_CHECK_EN adds a sticky out-of-range error.
module acc_mem_resp
  import acc_pkg::*;
#(
  parameter int DEPTH      = ACC_MEM_DEPTH,
  parameter int READ_LAT   = ACC_MEM_READ_LAT,
  parameter int WBUF_DEPTH = ACC_MEM_WBUF_DEPTH
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  mem_rden_i,
  input  addr_t mem_raddr_i,
  output logic  mem_rvalid_o,
  output data_t mem_rdata_o,
  input  logic  mem_wren_i,
  input  addr_t mem_waddr_i,
  input  data_t mem_wdata_i,
  output logic  mem_wready_o
`ifdef ACC_MEM_OOB_CHECK_EN
  ,
  output logic  mem_err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]    ridx, widx, pop_idx;
  data_t               pop_data, lkp_data, mem_word, rd_word;
  logic                wr_xfer, push, drain, wb_empty, wb_full_nxt, lkp_hit, wready_q;
  data_t               mem_q [DEPTH];
  logic [READ_LAT-1:0] vld_q;
  data_t               dat_q [READ_LAT];

  assign ridx    = mem_raddr_i[IDX_W-1:0];
  assign widx    = mem_waddr_i[IDX_W-1:0];
  assign wr_xfer = mem_wren_i && wready_q;
  // Reads own the single array port; the buffer only drains on read-free cycles.
  assign drain   = !mem_rden_i && !wb_empty;

`ifdef ACC_MEM_OOB_CHECK_EN
  logic r_oob, w_oob, err_q;

  assign r_oob = |mem_raddr_i[ADDR_WIDTH-1:IDX_W];
  assign w_oob = |mem_waddr_i[ADDR_WIDTH-1:IDX_W];
  assign push  = wr_xfer && !w_oob;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((mem_rden_i && r_oob) || (wr_xfer && w_oob)) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err_o = err_q;
`else
  logic unused_upper;

  assign unused_upper = ^{mem_raddr_i[ADDR_WIDTH-1:IDX_W], mem_waddr_i[ADDR_WIDTH-1:IDX_W]};
  assign push         = wr_xfer;
`endif

  acc_mem_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .IDX_W (IDX_W)
  ) u_wbuf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_idx  (widx),
    .push_data (mem_wdata_i),
    .pop       (drain),
    .pop_idx   (pop_idx),
    .pop_data  (pop_data),
    .empty     (wb_empty),
    .full_nxt  (wb_full_nxt),
    .lkp_idx   (ridx),
    .lkp_hit   (lkp_hit),
    .lkp_data  (lkp_data)
  );

  always_ff @(posedge clk_i) begin
    if (drain) mem_q[pop_idx] <= pop_data;
  end

  assign mem_word = mem_q[ridx];

  // The lookup sees only entries present at the start of the cycle, so a same-cycle write is invisible.
  always_comb begin
    rd_word = lkp_hit ? lkp_data : mem_word;
`ifdef ACC_MEM_OOB_CHECK_EN
    if (r_oob) rd_word = '0;
`endif
  end

  // Data stages only advance behind a valid so the output holds between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= mem_rden_i;
      if (mem_rden_i) dat_q[0] <= rd_word;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wready_q <= 1'b1;
    else         wready_q <= !wb_full_nxt;
  end

  assign mem_rvalid_o = vld_q[READ_LAT-1];
  assign mem_rdata_o  = dat_q[READ_LAT-1];
  assign mem_wready_o = wready_q;

endmodule

// File: tb/tb_acc_mem_resp.sv
// Self-checking bench for acc_mem_resp: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_acc_mem_resp;
  import acc_pkg::*;

  localparam int DEPTH = ACC_MEM_DEPTH;
  localparam int RL    = ACC_MEM_READ_LAT;
  localparam int WB    = ACC_MEM_WBUF_DEPTH;

  logic  clk, rst_ni;
  logic  mem_rden_i, mem_rvalid_o, mem_wren_i, mem_wready_o;
  addr_t mem_raddr_i, mem_waddr_i;
  data_t mem_rdata_o, mem_wdata_i;
`ifdef ACC_MEM_OOB_CHECK_EN
  logic  mem_err_o;
`endif

  acc_mem_resp dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mem_rden_i   (mem_rden_i),
    .mem_raddr_i  (mem_raddr_i),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_rdata_o  (mem_rdata_o),
    .mem_wren_i   (mem_wren_i),
    .mem_waddr_i  (mem_waddr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_wready_o (mem_wready_o)
`ifdef ACC_MEM_OOB_CHECK_EN
    ,
    .mem_err_o    (mem_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array contents, pending writes (oldest first), reads in flight.
  typedef struct { int idx; data_t d; } wentry_t;
  typedef struct { int due; data_t d; } rentry_t;
  typedef struct {
    bit rd; int ra; bit wr; int wa; data_t wd; bit ev; data_t ed;
  } vec_t;

  wentry_t wq[$];
  rentry_t rq[$];
  data_t   marr [DEPTH];
  data_t   last_d;
  bit      m_err;
  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  vec_t    vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_oob(input int a);
`ifdef ACC_MEM_OOB_CHECK_EN
    return a >= DEPTH;
`else
    return (a < 0);
`endif
  endfunction

  task automatic model_reset();
    wq.delete();
    rq.delete();
    last_d = '0;
    m_err  = 1'b0;
  endtask

  // One clock of traffic: checks wready before the edge, rvalid/rdata after it.
  task automatic cycle(input bit rd, input int ra, input bit wr, input int wa, input data_t wd);
    bit      exp_wr;
    data_t   res;
    int      ri, wi;
    rentry_t r;
    wentry_t w;
    mem_rden_i  = rd;
    mem_raddr_i = addr_t'(ra);
    mem_wren_i  = wr;
    mem_waddr_i = addr_t'(wa);
    mem_wdata_i = wd;
    exp_wr = (wq.size() < WB);
    check("wready", mem_wready_o, 32'(exp_wr));
    ri = ra % DEPTH;
    wi = wa % DEPTH;
    if (rd) begin
      res = marr[ri];
      foreach (wq[i]) if (wq[i].idx == ri) res = wq[i].d;
      if (is_oob(ra)) begin
        res   = '0;
        m_err = 1'b1;
      end
      r.due = cyc + RL;
      r.d   = res;
      rq.push_back(r);
    end else if (wq.size() > 0) begin
      w = wq.pop_front();
      marr[w.idx] = w.d;
    end
    if (wr && exp_wr) begin
      if (is_oob(wa)) m_err = 1'b1;
      else begin
        w.idx = wi;
        w.d   = wd;
        wq.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rvalid", mem_rvalid_o, 1);
      r = rq.pop_front();
      last_d = r.d;
    end else begin
      check("rvalid", mem_rvalid_o, 0);
    end
    check("rdata", mem_rdata_o, last_d);
`ifdef ACC_MEM_OOB_CHECK_EN
    check("err", mem_err_o, 32'(m_err));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0, 0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    rst_ni      = 1'b0;
    mem_rden_i  = 1'b0;
    mem_raddr_i = '0;
    mem_wren_i  = 1'b0;
    mem_waddr_i = '0;
    mem_wdata_i = '0;
    model_reset();

    // Reset state, then release with no traffic.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wready", mem_wready_o, 1);
    check("rst_rvalid", mem_rvalid_o, 0);
    check("rst_rdata", mem_rdata_o, 0);
    rst_ni = 1'b1;
    idle(3);
    check("post_rst_wready", mem_wready_o, 1);
    check("post_rst_rdata", mem_rdata_o, 0);

    // Forwarding and same-cycle write vectors (READ_LAT = 2).
    vecs[0] = '{1'b0, 0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5, 1'b0, 0, 32'h0,         1'b0, 32'h0};
    vecs[2] = '{1'b0, 0, 1'b0, 0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 0, 1'b0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 0, 1'b1, 7, 32'h9,         1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 0, 1'b0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 7, 1'b1, 7, 32'h1,         1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 7, 1'b0, 0, 32'h0,         1'b1, 32'h9};
    vecs[8] = '{1'b0, 0, 1'b0, 0, 32'h0,         1'b1, 32'h1};
    vecs[9] = '{1'b0, 0, 1'b0, 0, 32'h0,         1'b0, 32'h1};
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rd, vecs[i].ra, vecs[i].wr, vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_rvalid", i), mem_rvalid_o, 32'(vecs[i].ev));
      check($sformatf("vec%0d_rdata", i), mem_rdata_o, vecs[i].ed);
    end

    // Latency and back-to-back stream: preload i = i, read 0..9 consecutively.
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, i, data_t'(i));
    idle(4);
    for (int i = 0; i < RL + 12; i++) begin
      cycle(i < 10, i, 1'b0, 0, '0);
      k = i + 1 - RL;
      if (k >= 0 && k < 10) begin
        check("stream_rvalid", mem_rvalid_o, 1);
        check("stream_rdata", mem_rdata_o, 32'(k));
      end else begin
        check("stream_rvalid", mem_rvalid_o, 0);
      end
    end

    // Backpressure: continuous reads stall the drain until one read-free cycle.
    for (int i = 0; i < 6; i++) begin
      check("bp_wready", mem_wready_o, 32'(i < WB));
      cycle(1'b1, 0, 1'b1, 20 + i, data_t'(32'h100 + i));
    end
    check("bp_full_wready", mem_wready_o, 0);
    idle(1);
    check("bp_drain_wready", mem_wready_o, 1);
    cycle(1'b0, 0, 1'b1, 20, 32'h555);
    cycle(1'b1, 20, 1'b0, 0, '0);
    idle(RL - 1);
    check("bp_newest_rvalid", mem_rvalid_o, 1);
    check("bp_newest_rdata", mem_rdata_o, 32'h555);
    cycle(1'b1, 23, 1'b0, 0, '0);
    cycle(1'b1, 22, 1'b0, 0, '0);
    idle(RL + 4);

    // Reset mid-flight: two reads and three writes, reset lands before any valid.
    cycle(1'b0, 0, 1'b1, 3, 32'hBAD0);
    cycle(1'b1, 3, 1'b1, 4, 32'hBAD1);
    mem_rden_i  = 1'b1;
    mem_raddr_i = addr_t'(4);
    mem_wren_i  = 1'b1;
    mem_waddr_i = addr_t'(5);
    mem_wdata_i = 32'hBAD2;
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rvalid", mem_rvalid_o, 0);
    check("mid_rst_rdata", mem_rdata_o, 0);
    check("mid_rst_wready", mem_wready_o, 1);
    mem_rden_i = 1'b0;
    mem_wren_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("in_rst_rvalid", mem_rvalid_o, 0);
    end
    rst_ni = 1'b1;
    idle(RL + 2);
    cycle(1'b1, 3, 1'b0, 0, '0);
    idle(RL - 1);
    check("after_rst_rvalid", mem_rvalid_o, 1);
    check("after_rst_rdata", mem_rdata_o, 32'h3);
    cycle(1'b1, 5, 1'b0, 0, '0);
    cycle(1'b1, 4, 1'b0, 0, '0);
    idle(RL + 2);

    // Randomized traffic over a preloaded window, with aliased upper bits when allowed.
    for (int i = 0; i < 16; i++) cycle(1'b0, 0, 1'b1, i, $urandom);
    idle(6);
    for (int i = 0; i < 600; i++) begin
      int ra, wa;
      ra = $urandom_range(0, 15);
      wa = $urandom_range(0, 15);
`ifndef ACC_MEM_OOB_CHECK_EN
      ra = ra + DEPTH * $urandom_range(0, 255);
      wa = wa + DEPTH * $urandom_range(0, 255);
`endif
      cycle($urandom_range(0, 9) < 6, ra, 1'(($urandom_range(0, 1))), wa, $urandom);
    end
    idle(WB + RL + 2);

`ifdef ACC_MEM_OOB_CHECK_EN
    // Out-of-range accesses: read returns 0 with normal timing, write dropped, error sticks.
    cycle(1'b1, 300, 1'b0, 0, '0);
    idle(RL - 1);
    check("oob_rvalid", mem_rvalid_o, 1);
    check("oob_rdata", mem_rdata_o, 0);
    check("oob_err", mem_err_o, 1);
    cycle(1'b0, 0, 1'b1, 260, 32'h77);
    idle(3);
    cycle(1'b1, 4, 1'b0, 0, '0);
    idle(RL + 3);
    check("oob_err_sticky", mem_err_o, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
